i2c_master: RTL and testbench
=============================

# i2c_master

Single-byte I2C bus master that drives the serial bus shared by the slaves (the FIFO slave at address 7'b0011001 and its siblings). It accepts one parallel command (address, direction, write byte) from the system side, serialises START, address+R/W, ACK, one data byte, ACK and STOP onto SCL_O/SDA_O, and returns the read byte and the acknowledge status. It is the stage directly upstream of every slave: its SCL_O/SDA_O drive the slaves' SCL_I/SDA_I, and its SDA_I receives the slaves' SDA_O.

## Interface
Parameters:
- CLK_DIV, 4, clk cycles per SCL half-period; legal range 2..255.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  command request; accepted only when busy=0.
- rw  in  1  direction: 1 = read from slave, 0 = write to slave.
- addr  in  7  target slave address.
- wdata  in  8  byte to write (ignored when rw=1).
- busy  out  1  high from the cycle after acceptance until done.
- done  out  1  one-clk pulse at end of every transaction.
- ack_err  out  1  1 = a NACK was received; valid with done, held until next acceptance.
- rdata  out  8  byte read from slave; valid with done (rw=1), held until next acceptance.
- SCL_O  out  1  serial clock to slaves.
- SDA_O  out  1  serial data to slaves (1 = released/high).
- SDA_I  in  1  serial data from the addressed slave.

## Operation
- Reset (async, rst=0): state IDLE, SCL_O=1, SDA_O=1, busy=0, done=0, ack_err=0, rdata=0, counters 0. Reset mid-transaction aborts immediately; no done pulse.
- Acceptance: start=1 while IDLE latches addr, rw, wdata; start during busy is ignored (no queueing).
- States: IDLE -> START -> ADDR -> ACK1 -> (DATA -> ACK2 | NACK path) -> STOP -> IDLE.
- START: SDA_O=0 while SCL_O=1 for CLK_DIV clks, then SCL enters its low phase.
- Bit period: 2*CLK_DIV clks, SCL_O low for CLK_DIV then high for CLK_DIV. SDA_O updates only at mid-low (CLK_DIV/2, rounded down, clks after SCL falls) and is stable through the following high phase and the falling edge that ends it (slaves sample on SCL falling edge).
- ADDR: 8 bit periods, sends {addr[6:0], rw} MSB first; 3-bit bit counter counts 7 down to 0.
- ACK1: 1 bit period, SDA_O=1; SDA_I sampled on the last clk of the SCL high phase. SDA_I=0 -> DATA. SDA_I=1 -> ack_err=1, go directly to STOP (DATA/ACK2 skipped).
- DATA write: 8 bit periods, wdata MSB first. DATA read: SDA_O=1, SDA_I sampled at end of each high phase, shifted into rdata MSB first.
- ACK2 write: SDA_O=1, sample SDA_I; 1 -> ack_err=1. ACK2 read: master drives SDA_O=1 (NACK, last byte); ack_err unaffected.
- STOP: SCL low CLK_DIV clks with SDA_O=0, SCL high CLK_DIV clks with SDA_O=0, then SDA_O=1 for CLK_DIV clks (bus free); then done=1 one clk, busy=0 same clk, state IDLE.
- rdata is updated only on read transactions; write transactions leave it unchanged.

## Timing
- Acceptance at posedge N (start=1, IDLE): busy=1 and SDA_O=0 at N+1.
- Acked transaction: busy high exactly 40*CLK_DIV clks (CLK_DIV + 36*CLK_DIV + 3*CLK_DIV); 160 clks at CLK_DIV=4.
- Address NACK: busy high 22*CLK_DIV clks (88 at CLK_DIV=4).
- done coincides with busy falling; a new start on the done cycle is accepted (back-to-back transactions, SDA_O/SCL_O high for at least that clk).
- SCL_O never toggles while IDLE; SDA_O changes while SCL_O=1 only for START and STOP.

## Test plan
- Reset: assert rst=0 mid-ADDR -> SCL_O=1, SDA_O=1, busy=0, done never pulses; after release, idle bus.
- Write acked: addr=7'h19, rw=0, wdata=8'hA5, bench slave ACKs both -> serial bits 0011001_0 then 10100101, done at 160 clks after acceptance, ack_err=0.
- Read acked: addr=7'h19, rw=1, slave returns 8'h3C -> rdata=8'h3C, ack_err=0, master SDA_O=1 in ACK2, done at 160 clks.
- Address NACK: addr=7'h55, slave holds SDA_I=1 -> no DATA phase, ack_err=1, done 88 clks after acceptance.
- Data NACK on write: slave ACKs address, NACKs data -> ack_err=1, full 160-clk frame, STOP present.
- Busy/back-to-back: start pulsed during busy -> ignored; start on done cycle with new wdata=8'h00 -> second frame begins next clk, CLK_DIV=2 rerun gives 80-clk frames.

Source files
------------

// File: rtl/i2c_master.sv
// Single-byte I2C bus master: START, address+R/W, ACK, one data byte, ACK, STOP.
// SCL/SDA are decoded from the state and the phase counter; SDA data bits move only at mid-low.
module i2c_master #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic [7:0] rdata,
    output logic       SCL_O,
    output logic       SDA_O,
    input  logic       SDA_I
);
    localparam int CNT_W = $clog2(3 * CLK_DIV);
    localparam logic [CNT_W-1:0] HALF_END   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] HIGH_START = CNT_W'(CLK_DIV);
    localparam logic [CNT_W-1:0] BIT_END    = CNT_W'(2 * CLK_DIV - 1);
    localparam logic [CNT_W-1:0] FREE_START = CNT_W'(2 * CLK_DIV);
    localparam logic [CNT_W-1:0] STOP_END   = CNT_W'(3 * CLK_DIV - 1);
    // Registering at this count makes the new bit visible CLK_DIV/2 clks after SCL falls.
    localparam logic [CNT_W-1:0] MID_LOW    = CNT_W'(CLK_DIV / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_ADDR, S_ACK1, S_DATA, S_ACK2, S_STOP
    } state_t;

    state_t           state, next_state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       frame;
    logic [7:0]       wbyte;
    logic [7:0]       rx;
    logic             rd_mode;
    logic             sda_bit;
    logic             phase_end;

    always_comb begin
        phase_end = 1'b0;
        case (state)
            S_START:                        phase_end = (cnt == HALF_END);
            S_ADDR, S_ACK1, S_DATA, S_ACK2: phase_end = (cnt == BIT_END);
            S_STOP:                         phase_end = (cnt == STOP_END);
            default:                        phase_end = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start) next_state = S_START;
            S_START: if (phase_end) next_state = S_ADDR;
            S_ADDR:  if (phase_end && bit_cnt == 3'd0) next_state = S_ACK1;
            S_ACK1:  if (phase_end) next_state = SDA_I ? S_STOP : S_DATA;
            S_DATA:  if (phase_end && bit_cnt == 3'd0) next_state = S_ACK2;
            S_ACK2:  if (phase_end) next_state = S_STOP;
            S_STOP:  if (phase_end) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        SCL_O = 1'b1;
        SDA_O = 1'b1;
        busy  = 1'b1;
        case (state)
            S_IDLE:  busy = 1'b0;
            S_START: SDA_O = 1'b0;
            S_STOP: begin
                SCL_O = (cnt >= HIGH_START);
                SDA_O = (cnt >= FREE_START);
            end
            default: begin
                SCL_O = (cnt >= HIGH_START);
                SDA_O = sda_bit;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            bit_cnt <= '0;
            frame   <= '0;
            wbyte   <= '0;
            rx      <= '0;
            rd_mode <= 1'b0;
            sda_bit <= 1'b1;
            rdata   <= '0;
            ack_err <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == S_IDLE || phase_end) cnt <= '0;
            else                              cnt <= cnt + 1'b1;

            if (state == S_IDLE && start) begin
                frame   <= {addr, rw};
                wbyte   <= wdata;
                rd_mode <= rw;
                bit_cnt <= 3'd7;
                sda_bit <= 1'b0;
                ack_err <= 1'b0;
            end

            if (cnt == MID_LOW) begin
                case (state)
                    S_ADDR:         sda_bit <= frame[bit_cnt];
                    S_DATA:         sda_bit <= rd_mode | wbyte[bit_cnt];
                    S_ACK1, S_ACK2: sda_bit <= 1'b1;
                    default:        ;
                endcase
            end

            // SDA_I is taken on the last clk of the SCL high phase.
            if (phase_end) begin
                case (state)
                    S_ADDR: bit_cnt <= bit_cnt - 1'b1;
                    S_ACK1: if (SDA_I) ack_err <= 1'b1;
                    S_DATA: begin
                        bit_cnt <= bit_cnt - 1'b1;
                        rx      <= {rx[6:0], SDA_I};
                    end
                    S_ACK2: begin
                        if (rd_mode)    rdata   <= rx;
                        else if (SDA_I) ack_err <= 1'b1;
                    end
                    S_STOP: done <= 1'b1;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_master.sv
// Bench for i2c_master: two instances (CLK_DIV=4 and 2) behind a selector, a bus-level slave
// that decodes SCL/SDA and answers ACK/read data, and a frame-level reference model.
module tb_i2c_master;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sel = 1'b0;
    logic       start_r = 1'b0;
    logic       rw_r = 1'b0;
    logic [6:0] addr_r = '0;
    logic [7:0] wdata_r = '0;
    logic       sda_in = 1'b1;

    logic       start4, start2;
    logic       busy4, done4, ackerr4, scl4, sda4;
    logic       busy2, done2, ackerr2, scl2, sda2;
    logic [7:0] rdata4, rdata2;
    logic       busy_s, done_s, ackerr_s, scl_s, sda_s;
    logic [7:0] rdata_s;
    int         cd;

    int compared = 0;
    int mismatched = 0;
    logic [7:0] model_rd [2];

    // bus-slave configuration and monitor state
    bit         cfg_ack_a = 1'b1;
    bit         cfg_ack_d = 1'b1;
    logic [7:0] cfg_rbyte = '0;
    logic       p_scl = 1'b1, p_sda = 1'b1;
    bit         skip_fall = 1'b0;
    int         low_cnt = 0;
    int         stop_cnt = 0;
    int         sda_viol = 0;
    int         mon_n = 0;
    logic       bits_q[$];

    assign start4   = start_r & ~sel;
    assign start2   = start_r & sel;
    assign busy_s   = sel ? busy2 : busy4;
    assign done_s   = sel ? done2 : done4;
    assign ackerr_s = sel ? ackerr2 : ackerr4;
    assign rdata_s  = sel ? rdata2 : rdata4;
    assign scl_s    = sel ? scl2 : scl4;
    assign sda_s    = sel ? sda2 : sda4;
    assign cd       = sel ? 2 : 4;

    always #5 clk = ~clk;

    i2c_master #(.CLK_DIV(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .rw(rw_r), .addr(addr_r), .wdata(wdata_r),
        .busy(busy4), .done(done4), .ack_err(ackerr4), .rdata(rdata4),
        .SCL_O(scl4), .SDA_O(sda4), .SDA_I(sda_in)
    );

    i2c_master #(.CLK_DIV(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .rw(rw_r), .addr(addr_r), .wdata(wdata_r),
        .busy(busy2), .done(done2), .ack_err(ackerr2), .rdata(rdata2),
        .SCL_O(scl2), .SDA_O(sda2), .SDA_I(sda_in)
    );

    // Bus slave: bits taken at SCL falling edges, answers driven right after a fall.
    always @(negedge clk) begin
        if (!rst) begin
            sda_in    = 1'b1;
            skip_fall = 1'b0;
        end else begin
            if (p_scl && scl_s && p_sda && !sda_s) begin
                bits_q.delete();
                stop_cnt  = 0;
                sda_viol  = 0;
                skip_fall = 1'b1;
                sda_in    = 1'b1;
            end else if (p_scl && scl_s && !p_sda && sda_s) begin
                stop_cnt++;
            end
            if (p_scl && !scl_s) begin
                low_cnt = 0;
                if (skip_fall) begin
                    skip_fall = 1'b0;
                end else begin
                    bits_q.push_back(p_sda);
                    mon_n = bits_q.size();
                    if (mon_n == 8) sda_in = !cfg_ack_a;
                    else if (mon_n == 17) sda_in = !(cfg_ack_d && !bits_q[7]);
                    else if (mon_n >= 9 && mon_n <= 16 && bits_q[7]) sda_in = cfg_rbyte[3'(16 - mon_n)];
                    else sda_in = 1'b1;
                end
                if (p_sda != sda_s && mon_n != 9 && mon_n != 18) sda_viol++;
            end else if (!scl_s) begin
                low_cnt++;
                if (p_sda != sda_s && low_cnt != cd / 2) sda_viol++;
            end else if (!p_scl && p_sda != sda_s) begin
                sda_viol++;
            end
        end
        p_scl = scl_s;
        p_sda = sda_s;
    end

    // Frame-level expectation from the protocol rules.
    task automatic ref_frame(input int c, input logic [6:0] a, input logic r, input logic [7:0] w,
                             input bit aa, input bit ad, input logic [7:0] rb, input logic [7:0] old_rd,
                             output logic [17:0] bits, output int n, output int cyc,
                             output logic err, output logic [7:0] rd);
        if (!aa) begin
            bits = {9'b0, a, r, 1'b1};
            n = 9; cyc = 22 * c; err = 1'b1; rd = old_rd;
        end else begin
            bits = {a, r, 1'b1, (r ? 8'hFF : w), 1'b1};
            n = 18; cyc = 40 * c; err = !r && !ad; rd = r ? rb : old_rd;
        end
    endtask

    task automatic do_frame(input logic [6:0] a, input logic r, input logic [7:0] w,
                            input bit aa, input bit ad, input logic [7:0] rb, input bit now, input bit poke,
                            output int bcyc, output logic b_first, output logic s_first,
                            output logic d_end, output logic b_end, output logic [17:0] bits, output int nb);
        if (!now) @(negedge clk);
        cfg_ack_a = aa; cfg_ack_d = ad; cfg_rbyte = rb;
        addr_r = a; rw_r = r; wdata_r = w; start_r = 1'b1;
        @(negedge clk);
        start_r = 1'b0;
        b_first = busy_s;
        s_first = sda_s;
        bcyc = 0;
        while (busy_s === 1'b1 && bcyc < 4000) begin
            bcyc++;
            if (poke && bcyc == 10) begin
                addr_r = ~a; rw_r = ~r; wdata_r = ~w; start_r = 1'b1;
            end else begin
                addr_r = a; rw_r = r; wdata_r = w; start_r = 1'b0;
            end
            @(negedge clk);
        end
        start_r = 1'b0;
        d_end = done_s;
        b_end = busy_s;
        bits = '0;
        nb = bits_q.size();
        foreach (bits_q[i]) bits = {bits[16:0], bits_q[i]};
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        compared++;
        if ({scl4, sda4, busy4, done4, ackerr4} !== 5'b11000) begin
            mismatched++;
            $display("FAIL reset_ctrl: got scl/sda/busy/done/err=%b want 11000", {scl4, sda4, busy4, done4, ackerr4});
        end
        compared++;
        if (rdata4 !== 8'h00 || rdata2 !== 8'h00) begin
            mismatched++;
            $display("FAIL reset_rdata: got %h/%h want 00/00", rdata4, rdata2);
        end
        rst = 1'b1;
        repeat (4) @(negedge clk);
        compared++;
        if ({scl4, sda4, busy4, scl2, sda2, busy2} !== 6'b110110) begin
            mismatched++;
            $display("FAIL reset_idle: got %b want 110110", {scl4, sda4, busy4, scl2, sda2, busy2});
        end
        model_rd[0] = 8'h00;
        model_rd[1] = 8'h00;
    endtask

    task automatic test_write_ack();
        int bcyc, nb; logic bf, sf, de, be; logic [17:0] bits;
        sel = 1'b0;
        do_frame(7'h19, 1'b0, 8'hA5, 1, 1, 8'h00, 0, 0, bcyc, bf, sf, de, be, bits, nb);
        compared++;
        if (bits !== {7'h19, 1'b0, 1'b1, 8'hA5, 1'b1} || nb != 18) begin
            mismatched++;
            $display("FAIL write_bits: got %b (%0d) want %b (18)", bits, nb, {7'h19, 1'b0, 1'b1, 8'hA5, 1'b1});
        end
        compared++;
        if (bcyc != 160 || bf !== 1'b1 || sf !== 1'b0) begin
            mismatched++;
            $display("FAIL write_timing: got busy=%0d first busy/sda=%b%b want 160 10", bcyc, bf, sf);
        end
        compared++;
        if (de !== 1'b1 || be !== 1'b0 || ackerr_s !== 1'b0) begin
            mismatched++;
            $display("FAIL write_end: got done/busy/err=%b%b%b want 100", de, be, ackerr_s);
        end
        compared++;
        if (stop_cnt != 1 || sda_viol != 0) begin
            mismatched++;
            $display("FAIL write_bus: got stops=%0d sda_viol=%0d want 1 0", stop_cnt, sda_viol);
        end
    endtask

    task automatic test_read_ack();
        int bcyc, nb; logic bf, sf, de, be; logic [17:0] bits;
        sel = 1'b0;
        do_frame(7'h19, 1'b1, 8'h77, 1, 1, 8'h3C, 0, 0, bcyc, bf, sf, de, be, bits, nb);
        model_rd[0] = 8'h3C;
        compared++;
        if (bits !== {7'h19, 1'b1, 1'b1, 8'hFF, 1'b1} || nb != 18) begin
            mismatched++;
            $display("FAIL read_bits: got %b (%0d) want %b (18)", bits, nb, {7'h19, 1'b1, 1'b1, 8'hFF, 1'b1});
        end
        compared++;
        if (rdata_s !== 8'h3C || ackerr_s !== 1'b0) begin
            mismatched++;
            $display("FAIL read_data: got rdata=%h err=%b want 3c 0", rdata_s, ackerr_s);
        end
        compared++;
        if (bcyc != 160 || de !== 1'b1 || stop_cnt != 1 || sda_viol != 0) begin
            mismatched++;
            $display("FAIL read_frame: got busy=%0d done=%b stops=%0d viol=%0d want 160 1 1 0", bcyc, de, stop_cnt, sda_viol);
        end
    endtask

    task automatic test_addr_nack();
        int bcyc, nb; logic bf, sf, de, be; logic [17:0] bits;
        sel = 1'b0;
        do_frame(7'h55, 1'b0, 8'hFF, 0, 1, 8'h00, 0, 0, bcyc, bf, sf, de, be, bits, nb);
        compared++;
        if (bits !== {9'b0, 7'h55, 1'b0, 1'b1} || nb != 9) begin
            mismatched++;
            $display("FAIL nack_bits: got %b (%0d) want %b (9)", bits, nb, {9'b0, 7'h55, 1'b0, 1'b1});
        end
        compared++;
        if (bcyc != 88 || de !== 1'b1 || stop_cnt != 1) begin
            mismatched++;
            $display("FAIL nack_len: got busy=%0d done=%b stops=%0d want 88 1 1", bcyc, de, stop_cnt);
        end
        repeat (3) @(negedge clk);
        compared++;
        if (ackerr_s !== 1'b1 || rdata_s !== model_rd[0]) begin
            mismatched++;
            $display("FAIL nack_hold: got err=%b rdata=%h want 1 %h", ackerr_s, rdata_s, model_rd[0]);
        end
    endtask

    task automatic test_data_nack();
        int bcyc, nb; logic bf, sf, de, be; logic [17:0] bits;
        sel = 1'b0;
        do_frame(7'h19, 1'b0, 8'h5A, 1, 0, 8'h00, 0, 0, bcyc, bf, sf, de, be, bits, nb);
        compared++;
        if (bits !== {7'h19, 1'b0, 1'b1, 8'h5A, 1'b1} || nb != 18) begin
            mismatched++;
            $display("FAIL dnack_bits: got %b (%0d) want %b (18)", bits, nb, {7'h19, 1'b0, 1'b1, 8'h5A, 1'b1});
        end
        compared++;
        if (bcyc != 160 || ackerr_s !== 1'b1 || stop_cnt != 1 || sda_viol != 0) begin
            mismatched++;
            $display("FAIL dnack_frame: got busy=%0d err=%b stops=%0d viol=%0d want 160 1 1 0", bcyc, ackerr_s, stop_cnt, sda_viol);
        end
    endtask

    task automatic test_random();
        int bcyc, nb, ecyc, en; logic bf, sf, de, be, eerr; logic [17:0] bits, ebits; logic [7:0] erd;
        logic [6:0] a; logic r; logic [7:0] w, rb; bit aa, ad;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            sel = 1'($urandom_range(0, 1));
            a = 7'($urandom); r = 1'($urandom); w = 8'($urandom); rb = 8'($urandom);
            aa = ($urandom_range(0, 3) != 0); ad = ($urandom_range(0, 3) != 0);
            do_frame(a, r, w, aa, ad, rb, 0, 0, bcyc, bf, sf, de, be, bits, nb);
            ref_frame(cd, a, r, w, aa, ad, rb, model_rd[sel], ebits, en, ecyc, eerr, erd);
            model_rd[sel] = erd;
            compared++;
            if (bits !== ebits || nb != en) begin
                mismatched++;
                $display("FAIL rand%0d_bits: got %b (%0d) want %b (%0d)", i, bits, nb, ebits, en);
            end
            compared++;
            if (bcyc != ecyc || bf !== 1'b1 || sf !== 1'b0 || de !== 1'b1 || be !== 1'b0) begin
                mismatched++;
                $display("FAIL rand%0d_timing: got busy=%0d first=%b%b end=%b%b want %0d 10 10", i, bcyc, bf, sf, de, be, ecyc);
            end
            compared++;
            if (ackerr_s !== eerr || rdata_s !== erd) begin
                mismatched++;
                $display("FAIL rand%0d_result: got err=%b rdata=%h want %b %h", i, ackerr_s, rdata_s, eerr, erd);
            end
            compared++;
            if (stop_cnt != 1 || sda_viol != 0) begin
                mismatched++;
                $display("FAIL rand%0d_bus: got stops=%0d viol=%0d want 1 0", i, stop_cnt, sda_viol);
            end
        end
    endtask

    task automatic test_reset_mid();
        int done_seen, idle_bad;
        sel = 1'b0;
        @(negedge clk);
        cfg_ack_a = 1'b1; addr_r = 7'h19; rw_r = 1'b0; wdata_r = 8'hA5; start_r = 1'b1;
        @(negedge clk);
        start_r = 1'b0;
        repeat (8) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        compared++;
        if ({scl4, sda4, busy4, done4} !== 4'b1100) begin
            mismatched++;
            $display("FAIL rstmid_async: got scl/sda/busy/done=%b want 1100", {scl4, sda4, busy4, done4});
        end
        done_seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (done4) done_seen++;
        end
        rst = 1'b1;
        idle_bad = 0;
        repeat (12) begin
            @(negedge clk);
            if (done4) done_seen++;
            if (!scl4 || !sda4 || busy4) idle_bad++;
        end
        compared++;
        if (done_seen != 0 || idle_bad != 0) begin
            mismatched++;
            $display("FAIL rstmid_idle: got done pulses=%0d idle faults=%0d want 0 0", done_seen, idle_bad);
        end
        compared++;
        if (ackerr4 !== 1'b0 || rdata4 !== 8'h00) begin
            mismatched++;
            $display("FAIL rstmid_regs: got err=%b rdata=%h want 0 00", ackerr4, rdata4);
        end
        model_rd[0] = 8'h00;
        model_rd[1] = 8'h00;
    endtask

    task automatic test_back_to_back();
        int bcyc, nb; logic bf, sf, de, be; logic [17:0] bits;
        sel = 1'b1;
        do_frame(7'h19, 1'b0, 8'hC3, 1, 1, 8'h00, 0, 1, bcyc, bf, sf, de, be, bits, nb);
        compared++;
        if (bits !== {7'h19, 1'b0, 1'b1, 8'hC3, 1'b1} || bcyc != 80) begin
            mismatched++;
            $display("FAIL b2b_first: got %b busy=%0d want %b 80", bits, bcyc, {7'h19, 1'b0, 1'b1, 8'hC3, 1'b1});
        end
        compared++;
        if (de !== 1'b1 || scl_s !== 1'b1 || sda_s !== 1'b1) begin
            mismatched++;
            $display("FAIL b2b_done_bus: got done/scl/sda=%b%b%b want 111", de, scl_s, sda_s);
        end
        do_frame(7'h19, 1'b0, 8'h00, 1, 1, 8'h00, 1, 0, bcyc, bf, sf, de, be, bits, nb);
        compared++;
        if (bf !== 1'b1 || sf !== 1'b0 || bcyc != 80) begin
            mismatched++;
            $display("FAIL b2b_second_timing: got first busy/sda=%b%b busy=%0d want 10 80", bf, sf, bcyc);
        end
        compared++;
        if (bits !== {7'h19, 1'b0, 1'b1, 8'h00, 1'b1} || ackerr_s !== 1'b0 || de !== 1'b1) begin
            mismatched++;
            $display("FAIL b2b_second_bits: got %b err=%b done=%b want %b 0 1", bits, ackerr_s, de, {7'h19, 1'b0, 1'b1, 8'h00, 1'b1});
        end
    endtask

    initial begin
        test_reset();
        test_write_ack();
        test_read_ack();
        test_addr_nack();
        test_data_nack();
        test_random();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
